morse_key_capture: RTL and testbench

- Front end of the Morse translator; sits directly upstream of the letter decoder.
- Samples the raw telegraph key/button, debounces it and times each press to classify it as dot or dash.
- Packs up to 4 symbols into the 8-bit right-aligned letter code: dot = 01, dash = 11, unused leading pairs = 00.
- Emits the code with a one-cycle strobe once an inter-letter gap elapses.

---
 rtl/morse_pkg.sv | 25 ++
 rtl/key_debouncer.sv | 57 +++++
 rtl/morse_key_capture.sv | 121 ++++++++++++
 tb/tb_morse_key_capture.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse constants and types for the key-capture front end and the letter decoder.
package morse_pkg;

    // Two-bit symbol codes packed right-aligned into an 8-bit letter code.
    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b11;

    // Longest letter the 8-bit code can hold.
    localparam int MAX_SYMBOLS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP,
        ST_LATCH,
        ST_STROBE
    } capture_state_t;

    // Maps a press classification onto its symbol code.
    function automatic logic [1:0] classify(input logic is_dash);
        return is_dash ? SYM_DASH : SYM_DOT;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer followed by a stability-count debouncer with edge pulses.
module key_debouncer #(
    parameter int CNT_W           = 27,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic clean_out,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] DEBOUNCE_LIM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] stable_cnt;
    logic             toggle;

    // The debounced value flips once the synced value has disagreed long enough.
    assign toggle = (sync_2 != clean_out) && (stable_cnt == DEBOUNCE_LIM);

    // Bring the raw key into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw_in;
            sync_2 <= sync_1;
        end
    end

    // Count disagreement cycles; update the clean value and emit single-cycle edge pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_cnt <= '0;
            clean_out  <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            rise <= toggle && sync_2;
            fall <= toggle && !sync_2;
            if (sync_2 == clean_out || toggle) begin
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
            if (toggle) begin
                clean_out <= sync_2;
            end
        end
    end

endmodule

// File: rtl/morse_key_capture.sv
// Times debounced key presses, packs dots/dashes into a letter code and strobes it after a gap.
module morse_key_capture
    import morse_pkg::*;
#(
    parameter int CNT_W           = 27,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DASH_CYCLES     = 20_000_000,
    parameter int GAP_CYCLES      = 60_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_in,
    output logic [7:0] letter_bits,
    output logic       letter_valid,
    output logic [2:0] symbol_count,
    output logic       overflow,
    output logic       busy
);

    // The press counter is cleared in the cycle the rise is seen, so it lags the
    // true debounced press length by one; the dash threshold compensates.
    localparam logic [CNT_W-1:0] DASH_LIM = CNT_W'(DASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES - 1);

    capture_state_t   state;
    logic [CNT_W-1:0] press_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic [7:0]       shadow;
    logic             overflow_pending;
    logic             press_pending;
    logic             key_clean;
    logic             key_rise;
    logic             key_fall;

    key_debouncer #(
        .CNT_W          (CNT_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .reset    (reset),
        .raw_in   (key_in),
        .clean_out(key_clean),
        .rise     (key_rise),
        .fall     (key_fall)
    );

    assign busy = (symbol_count != 3'd0) || key_clean;

    // Letter capture FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            press_cnt        <= '0;
            gap_cnt          <= '0;
            shadow           <= '0;
            overflow_pending <= 1'b0;
            press_pending    <= 1'b0;
            letter_bits      <= 8'h00;
            letter_valid     <= 1'b0;
            symbol_count     <= 3'd0;
            overflow         <= 1'b0;
        end else begin
            // NOTE: default-low here makes letter_valid a one-cycle pulse without extra state.
            letter_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_rise || press_pending) begin
                        press_cnt     <= '0;
                        press_pending <= 1'b0;
                        state         <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (press_cnt != '1) begin
                        press_cnt <= press_cnt + 1'b1;
                    end
                    if (key_fall) begin
                        if (symbol_count < 3'(MAX_SYMBOLS)) begin
                            shadow       <= {shadow[5:0], classify(press_cnt >= DASH_LIM)};
                            symbol_count <= symbol_count + 3'd1;
                        end else begin
                            overflow_pending <= 1'b1;
                        end
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (key_rise) begin
                        press_cnt <= '0;
                        state     <= ST_PRESS;
                    end else if (gap_cnt == GAP_LIM) begin
                        state <= ST_LATCH;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_LATCH: begin
                    letter_bits <= overflow_pending ? 8'h00 : shadow;
                    overflow    <= overflow_pending;
                    if (key_rise) begin
                        press_pending <= 1'b1;
                    end
                    state <= ST_STROBE;
                end
                ST_STROBE: begin
                    letter_valid     <= 1'b1;
                    shadow           <= {MAX_SYMBOLS{SYM_NONE}};
                    symbol_count     <= 3'd0;
                    overflow_pending <= 1'b0;
                    if (key_rise) begin
                        press_pending <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_key_capture.sv
// Directed self-checking bench for morse_key_capture with shortened timing parameters.
module tb_morse_key_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_in = 1'b0;
    logic [7:0] letter_bits;
    logic       letter_valid;
    logic [2:0] symbol_count;
    logic       overflow;
    logic       busy;

    int n_cmp = 0;
    int n_mis = 0;
    int valid_seen = 0;

    morse_key_capture #(
        .CNT_W          (27),
        .DEBOUNCE_CYCLES(4),
        .DASH_CYCLES    (20),
        .GAP_CYCLES     (50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_in      (key_in),
        .letter_bits (letter_bits),
        .letter_valid(letter_valid),
        .symbol_count(symbol_count),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Count every letter_valid pulse seen on a rising edge.
    always @(posedge clk) begin
        if (letter_valid) valid_seen++;
    end

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive key_in to v for n cycles, starting and ending on a falling edge.
    task automatic hold(input logic v, input int n);
        key_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for letter_valid, sampling on falling edges.
    task automatic wait_letter(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (letter_valid) got = 1'b1;
        end
    endtask

    initial begin
        bit got;
        int base;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bits", letter_bits, 8'h00);
        check("rst_valid", {7'd0, letter_valid}, 8'd0);
        check("rst_count", {5'd0, symbol_count}, 8'd0);
        check("rst_ovf", {7'd0, overflow}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single dot -> E
        base = valid_seen;
        hold(1'b1, 10);
        key_in = 1'b0;
        wait_letter(200, got);
        check("e_got", {7'd0, got}, 8'd1);
        check("e_bits", letter_bits, 8'b0000_0001);
        check("e_ovf", {7'd0, overflow}, 8'd0);
        @(negedge clk);
        check("e_pulse_low", {7'd0, letter_valid}, 8'd0);
        hold(1'b0, 10);
        check("e_pulses", 8'(valid_seen - base), 8'd1);
        check("e_bits_held", letter_bits, 8'b0000_0001);

        // A = dot dash
        hold(1'b1, 10);
        hold(1'b0, 15);
        check("a_count1", {5'd0, symbol_count}, 8'd1);
        check("a_busy", {7'd0, busy}, 8'd1);
        hold(1'b1, 30);
        hold(1'b0, 10);
        check("a_count2", {5'd0, symbol_count}, 8'd2);
        wait_letter(200, got);
        check("a_got", {7'd0, got}, 8'd1);
        check("a_bits", letter_bits, 8'b0000_0111);
        check("a_count0", {5'd0, symbol_count}, 8'd0);
        hold(1'b0, 5);

        // Dash threshold: exactly 20 cycles -> T
        hold(1'b1, 20);
        key_in = 1'b0;
        wait_letter(200, got);
        check("t20_got", {7'd0, got}, 8'd1);
        check("t20_bits", letter_bits, 8'b0000_0011);
        hold(1'b0, 5);

        // 19 cycles -> dot
        hold(1'b1, 19);
        key_in = 1'b0;
        wait_letter(200, got);
        check("d19_got", {7'd0, got}, 8'd1);
        check("d19_bits", letter_bits, 8'b0000_0001);
        hold(1'b0, 5);

        // Bounce: single-cycle glitches never become symbols
        base = valid_seen;
        repeat (6) begin
            hold(1'b1, 1);
            hold(1'b0, 2);
        end
        hold(1'b0, 100);
        check("bnc_pulses", 8'(valid_seen - base), 8'd0);
        check("bnc_count", {5'd0, symbol_count}, 8'd0);
        check("bnc_busy", {7'd0, busy}, 8'd0);

        // B = dash dot dot dot
        hold(1'b1, 30);
        hold(1'b0, 10);
        repeat (2) begin
            hold(1'b1, 10);
            hold(1'b0, 10);
        end
        hold(1'b1, 10);
        key_in = 1'b0;
        wait_letter(200, got);
        check("b_got", {7'd0, got}, 8'd1);
        check("b_bits", letter_bits, 8'b1101_0101);
        hold(1'b0, 5);

        // Overflow: five dots
        repeat (4) begin
            hold(1'b1, 10);
            hold(1'b0, 10);
        end
        check("ovf_count4", {5'd0, symbol_count}, 8'd4);
        hold(1'b1, 10);
        key_in = 1'b0;
        wait_letter(200, got);
        check("ovf_got", {7'd0, got}, 8'd1);
        check("ovf_bits", letter_bits, 8'h00);
        check("ovf_flag", {7'd0, overflow}, 8'd1);
        hold(1'b0, 5);
        check("ovf_held", {7'd0, overflow}, 8'd1);

        // Next letter clears overflow
        hold(1'b1, 25);
        key_in = 1'b0;
        wait_letter(200, got);
        check("ovf_t_got", {7'd0, got}, 8'd1);
        check("ovf_t_bits", letter_bits, 8'b0000_0011);
        check("ovf_t_flag", {7'd0, overflow}, 8'd0);
        hold(1'b0, 5);

        // Reset mid-letter
        base = valid_seen;
        hold(1'b1, 10);
        hold(1'b0, 10);
        hold(1'b1, 10);
        hold(1'b0, 10);
        check("rm_count2", {5'd0, symbol_count}, 8'd2);
        reset = 1'b1;
        #1;
        check("rm_count_async", {5'd0, symbol_count}, 8'd0);
        check("rm_bits_async", letter_bits, 8'h00);
        check("rm_busy_async", {7'd0, busy}, 8'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        hold(1'b0, 100);
        check("rm_pulses", 8'(valid_seen - base), 8'd0);
        check("rm_count0", {5'd0, symbol_count}, 8'd0);
        hold(1'b1, 25);
        key_in = 1'b0;
        wait_letter(200, got);
        check("rm_t_got", {7'd0, got}, 8'd1);
        check("rm_t_bits", letter_bits, 8'b0000_0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
